// File: rtl/ball_motion.sv
// Ball position, direction and life-state tracker for the Breakout playfield.
// Advances the ball on posUpdate, resolves wall/paddle/brick bounces on
// dirUpdate, and runs the serve / lose / game-over sequence.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   posUpdate           strobe: move ball one STEP along current direction
//   dirUpdate           strobe: evaluate collisions, update direction
//   launch              serve button (level; edge-qualified out of game over)
//   paddleX             paddle left edge
//   brickHit/brickSide  brick collision pulse and face (1 = left/right)
//   ballX, ballY        registered ball top-left corner
//   ballActive          ball in flight
//   ballLost            one-cycle pulse when the ball leaves the bottom
//   lives, gameOver     remaining lives, no lives left
module ball_motion #(
  parameter int unsigned H_MAX      = 640,
  parameter int unsigned V_MAX      = 480,
  parameter int unsigned BALL_SIZE  = 8,
  parameter int unsigned PADDLE_Y   = 440,
  parameter int unsigned PADDLE_W   = 64,
  parameter int unsigned STEP       = 1,
  parameter int unsigned LIVES_INIT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       posUpdate,
  input  logic       dirUpdate,
  input  logic       launch,
  input  logic [9:0] paddleX,
  input  logic       brickHit,
  input  logic       brickSide,
  output logic [9:0] ballX,
  output logic [8:0] ballY,
  output logic       ballActive,
  output logic       ballLost,
  output logic [1:0] lives,
  output logic       gameOver
);

  localparam logic [9:0]  XMax      = 10'(H_MAX - BALL_SIZE);
  localparam logic [8:0]  YMax      = 9'(V_MAX - BALL_SIZE);
  localparam logic [9:0]  XHome     = 10'(H_MAX / 2 - BALL_SIZE / 2);
  localparam logic [8:0]  YHome     = 9'(PADDLE_Y - BALL_SIZE);
  localparam logic [9:0]  XCenter   = 10'(PADDLE_W / 2 - BALL_SIZE / 2);
  localparam logic [1:0]  LivesInit = 2'(LIVES_INIT);
  localparam logic [10:0] StepX     = 11'(STEP);
  localparam logic [9:0]  StepY     = 10'(STEP);
  localparam logic [10:0] BallW     = 11'(BALL_SIZE);
  localparam logic [10:0] PaddleW   = 11'(PADDLE_W);

  typedef enum logic [1:0] {StHold, StMove, StLost, StOver} state_e;

  state_e     state_q, state_d;
  logic [9:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic       dx_pos_q, dx_pos_d;  // 1: moving right
  logic       dy_pos_q, dy_pos_d;  // 1: moving down
  logic       hflag_q, hflag_d;    // pending left/right brick face hit
  logic       vflag_q, vflag_d;    // pending top/bottom brick face hit
  logic [1:0] lives_q, lives_d;
  logic       need_release_q, need_release_d;
  logic       launch_q;
  logic       active_q, lost_q, over_q;

  logic hit_h, hit_v, paddle_hit, flip_x, flip_y;

  // Saturating moves: the ball stops at the playfield edge instead of wrapping.
  function automatic logic [9:0] step_x(input logic [9:0] x, input logic pos);
    logic [10:0] wide;
    if (pos) begin
      wide   = {1'b0, x} + StepX;
      step_x = (wide > {1'b0, XMax}) ? XMax : wide[9:0];
    end else begin
      step_x = ({1'b0, x} < StepX) ? '0 : x - StepX[9:0];
    end
  endfunction

  function automatic logic [8:0] step_y(input logic [8:0] y, input logic pos);
    logic [9:0] wide;
    if (pos) begin
      wide   = {1'b0, y} + StepY;
      step_y = (wide > {1'b0, YMax}) ? YMax : wide[8:0];
    end else begin
      step_y = ({1'b0, y} < StepY) ? '0 : y - StepY[8:0];
    end
  endfunction

  always_comb begin
    state_d        = state_q;
    x_d            = x_q;
    y_d            = y_q;
    dx_pos_d       = dx_pos_q;
    dy_pos_d       = dy_pos_q;
    hflag_d        = hflag_q;
    vflag_d        = vflag_q;
    lives_d        = lives_q;
    need_release_d = need_release_q;

    // A brick hit arriving with dirUpdate joins that same evaluation.
    hit_h      = hflag_q | (brickHit & brickSide);
    hit_v      = vflag_q | (brickHit & ~brickSide);
    paddle_hit = dy_pos_q && (y_q == YHome) &&
                 (({1'b0, x_q} + BallW) > {1'b0, paddleX}) &&
                 ({1'b0, x_q} < ({1'b0, paddleX} + PaddleW));
    // Causes are ORed so coincident causes flip an axis only once.
    flip_x = (x_q == '0 && !dx_pos_q) || (x_q == XMax && dx_pos_q) || hit_h;
    flip_y = (y_q == '0 && !dy_pos_q) || paddle_hit || hit_v;

    case (state_q)
      StHold: begin
        x_d     = paddleX + XCenter;
        y_d     = YHome;
        hflag_d = 1'b0;
        vflag_d = 1'b0;
        if (!launch) need_release_d = 1'b0;
        if (launch && !need_release_q) begin
          state_d  = StMove;
          dx_pos_d = 1'b1;
          dy_pos_d = 1'b0;
        end
      end
      StMove: begin
        if (dirUpdate) begin
          hflag_d = 1'b0;
          vflag_d = 1'b0;
          if (y_q >= YMax) begin
            state_d = StLost;
          end else begin
            dx_pos_d = dx_pos_q ^ flip_x;
            dy_pos_d = dy_pos_q ^ flip_y;
          end
        end else begin
          hflag_d = hit_h;
          vflag_d = hit_v;
        end
        // Move uses the direction just resolved above.
        if (posUpdate) begin
          x_d = step_x(x_q, dx_pos_d);
          y_d = step_y(y_q, dy_pos_d);
        end
      end
      StLost: begin
        lives_d = lives_q - 2'd1;
        hflag_d = 1'b0;
        vflag_d = 1'b0;
        if (lives_q == 2'd1) begin
          state_d = StOver;
          x_d     = XHome;
          y_d     = YHome;
        end else begin
          state_d = StHold;
        end
      end
      StOver: begin
        x_d     = XHome;
        y_d     = YHome;
        hflag_d = 1'b0;
        vflag_d = 1'b0;
        // Fresh press only; the held button must then be released to serve.
        if (launch && !launch_q) begin
          lives_d        = LivesInit;
          state_d        = StHold;
          need_release_d = 1'b1;
        end
      end
      default: state_d = StHold;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StHold;
      x_q            <= XHome;
      y_q            <= YHome;
      dx_pos_q       <= 1'b1;
      dy_pos_q       <= 1'b0;
      hflag_q        <= 1'b0;
      vflag_q        <= 1'b0;
      lives_q        <= LivesInit;
      need_release_q <= 1'b0;
      launch_q       <= 1'b0;
      active_q       <= 1'b0;
      lost_q         <= 1'b0;
      over_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      x_q            <= x_d;
      y_q            <= y_d;
      dx_pos_q       <= dx_pos_d;
      dy_pos_q       <= dy_pos_d;
      hflag_q        <= hflag_d;
      vflag_q        <= vflag_d;
      lives_q        <= lives_d;
      need_release_q <= need_release_d;
      launch_q       <= launch;
      active_q       <= (state_d == StMove);
      lost_q         <= (state_d == StLost);
      over_q         <= (state_d == StOver);
    end
  end

  assign ballX      = x_q;
  assign ballY      = y_q;
  assign ballActive = active_q;
  assign ballLost   = lost_q;
  assign lives      = lives_q;
  assign gameOver   = over_q;

endmodule

// File: doc/ball_motion.md
Name: ball_motion

Overview:
- Consumes the ball-timing strobes (position, direction and brick-update ticks) and maintains the ball's position, direction and life state for the Breakout playfield.
- Sits between the ball clock divider and the VGA renderer / brick-collision logic.
- Outputs registered ball coordinates for the renderer and a loss pulse for score/lives handling.

Parameters:
- H_MAX, 640, playfield width in pixels
- V_MAX, 480, playfield height in pixels
- BALL_SIZE, 8, ball edge length in pixels
- PADDLE_Y, 440, top row of the paddle
- PADDLE_W, 64, paddle width in pixels
- STEP, 1, pixels moved per posUpdate
- LIVES_INIT, 3, lives at reset and restart

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- posUpdate  in  1  one-cycle strobe: advance ball position
- dirUpdate  in  1  one-cycle strobe: evaluate collisions and update direction
- launch  in  1  serve button, level-sensitive, sampled each clk
- paddleX  in  10  paddle left edge, 0..H_MAX-PADDLE_W
- brickHit  in  1  one-cycle pulse from brick logic: ball hit a brick
- brickSide  in  1  qualifies brickHit: 0 = top/bottom face (flip dy), 1 = left/right face (flip dx)
- ballX  out  10  ball left edge
- ballY  out  9  ball top edge
- ballActive  out  1  high in MOVE
- ballLost  out  1  one-cycle pulse when the ball leaves the bottom edge
- lives  out  2  remaining lives
- gameOver  out  1  high in GAMEOVER

Behaviour:
- This block has one clock, clk. rst is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = HOLD
  - ballX = H_MAX/2 - BALL_SIZE/2 (316)
  - ballY = PADDLE_Y - BALL_SIZE (432)
  - dx = +, dy = up (−)
  - pending brick flags = 0
  - lives = LIVES_INIT
  - ballLost = 0, ballActive = 0, gameOver = 0
- HOLD:
  - Every cycle: ballX <= paddleX + PADDLE_W/2 - BALL_SIZE/2, ballY <= PADDLE_Y - BALL_SIZE.
  - Strobes are ignored; pending brick flags are cleared.
  - launch = 1 -> MOVE on the next cycle, with dx = +, dy = up.
- MOVE, on dirUpdate (collision conditions use the current registered position):
  - Flip dx if any of: ballX == 0 with dx −; ballX == H_MAX - BALL_SIZE with dx +; pending horizontal brick flag set.
  - Flip dy if any of:
    - ballY == 0 with dy −.
    - Paddle hit: dy + and ballY + BALL_SIZE == PADDLE_Y and ballX + BALL_SIZE > paddleX and ballX < paddleX + PADDLE_W. A paddle hit sets dy to −.
    - Pending vertical brick flag set.
  - Multiple causes on one axis flip that axis exactly once (OR, not XOR).
  - Pending brick flags are cleared after evaluation.
  - If ballY >= V_MAX - BALL_SIZE -> LOST; no direction change that cycle.
- MOVE, on posUpdate:
  - ballX <= ballX ± STEP, ballY <= ballY ± STEP.
  - Results are clamped to 0..H_MAX-BALL_SIZE and 0..V_MAX-BALL_SIZE. No wrap-around.
- Brick flags:
  - brickHit sets the pending flag selected by brickSide; flags are held until the next dirUpdate in MOVE.
  - brickHit coincident with dirUpdate is included in that same evaluation.
  - Repeat hits before consumption are idempotent.
- Simultaneous strobes: if posUpdate and dirUpdate arrive in the same cycle, the direction is evaluated first and the move uses the new direction. Normal strobe ordering is brick, then dir, then pos on consecutive cycles.
- LOST (one cycle):
  - ballLost = 1 and lives <= lives - 1.
  - If lives was 1 -> GAMEOVER, else -> HOLD.
- GAMEOVER:
  - gameOver = 1; ball is parked at the reset position.
  - On launch: lives <= LIVES_INIT, then -> HOLD (no immediate serve).
  - The serve requires launch to be released and pressed again; launch is edge-qualified from GAMEOVER only.
- rst asserted mid-operation, in any state, restores all reset values on the next clk edge.

Test Plan:
- Reset, then paddleX = 100 for 2 cycles -> ballX = 128, ballY = 432, ballActive = 0, lives = 3.
- Launch from HOLD, then 10 posUpdate strobes without collisions -> ballX = 138, ballY = 422.
- Ball at ballX = 632 with dx +, apply dirUpdate then posUpdate -> dx becomes −, ballX = 631. Mirror the check at ballY = 0 (dy flips to +).
- Ball at ballY = 432 with dy +, paddleX = 100, ballX = 95 -> dy flips on dirUpdate. Repeat with ballX = 92 (no overlap) -> no flip, ball continues down to LOST.
- brickHit with brickSide = 0 on the same cycle as dirUpdate, with the ball also at the top wall -> dy flips exactly once and the flags are cleared.
- Lose the ball three times from reset -> ballLost pulses each time, lives goes 2, 1, 0, then gameOver = 1. Launch -> lives = 3, state HOLD.
